// File: rtl/sp_mem_responder_pkg.sv
// Shared types and default sizes for the SP-array memory responder.
// Holds the FSM state and operation encodings plus a lane-index width helper.
package tinygpu_mem_pkg;

  localparam int DEF_N_CORES = 8;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  // A single-lane array still needs a one-bit index.
  function automatic int laneIdxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_mem_responder_if.sv
// Core-side bus between the SP lane array (master) and the memory responder (slave).
// Carries the broadcast request, per-lane packed address/data and the returned read data.
interface sp_mem_responder_if
  import tinygpu_mem_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic                      MRead;
  logic                      MWrite;
  logic                      MReady;
  logic [N_CORES-1:0]        en;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] data;
  logic [N_CORES*DATA_W-1:0] q;
  logic                      err;

  modport master (
    output MRead, MWrite, en, addr, data,
    input  MReady, q, err
  );

  modport slave (
    input  MRead, MWrite, en, addr, data,
    output MReady, q, err
  );

endinterface

// File: rtl/sp_mem_responder_lane_prio_enc.sv
// Lowest-set-bit priority encoder: picks the next pending lane to service.
// o_valid is low when no request bit is set.
module lane_prio_enc
  import tinygpu_mem_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int IDX_W   = laneIdxW(N_CORES)
) (
  input  logic [N_CORES-1:0] i_req,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scanning from the top lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_mem_responder.sv
// Serialises one broadcast lane-array read/write onto a single-port synchronous RAM,
// gathers per-lane read data and completes the 4-phase MRead/MWrite -> MReady handshake.
module sp_mem_responder
  import tinygpu_mem_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  sp_mem_responder_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = laneIdxW(N_CORES);

  state_t                    r_state;
  state_t                    w_nextState;
  op_t                       r_op;
  logic [N_CORES-1:0]        r_pending;
  logic [N_CORES*ADDR_W-1:0] r_addr;
  logic [N_CORES*DATA_W-1:0] r_data;
  logic [N_CORES*DATA_W-1:0] r_q;
  logic                      r_err;
  logic                      r_rdVld;
  logic [IDX_W-1:0]          r_rdLane;

  logic                      w_req;
  logic [IDX_W-1:0]          w_lane;
  logic                      w_laneVld;
  logic [N_CORES-1:0]        w_pendingNext;
  logic                      w_lastIssue;

  lane_prio_enc #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_prioEnc (
    .i_req   (r_pending),
    .o_idx   (w_lane),
    .o_valid (w_laneVld)
  );

  assign w_req         = bus.MRead | bus.MWrite;
  assign w_pendingNext = r_pending & ~({{(N_CORES-1){1'b0}}, 1'b1} << w_lane);
  assign w_lastIssue   = (w_pendingNext == '0);
  assign bus.q         = r_q;
  assign bus.err       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_req) w_nextState = (bus.en != '0) ? ISSUE : DONE;
      ISSUE:   if (w_lastIssue) w_nextState = (r_op == READ) ? DRAIN : DONE;
      DRAIN:   w_nextState = DONE;
      DONE:    if (!w_req) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // RAM strobes only ever leave ISSUE; elsewhere the bus is parked at zero.
  always_comb begin
    bus.MReady = (r_state == DONE);
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (r_state == ISSUE) begin
      mem_addr  = r_addr[w_lane*ADDR_W +: ADDR_W];
      mem_wdata = r_data[w_lane*DATA_W +: DATA_W];
      mem_we    = w_laneVld && (r_op == WRITE);
      mem_re    = w_laneVld && (r_op == READ);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_op      <= READ;
      r_err     <= 1'b0;
      r_q       <= '0;
      r_rdVld   <= 1'b0;
      r_rdLane  <= '0;
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_pending <= bus.en;
        r_addr    <= bus.addr;
        r_data    <= bus.data;
        r_op      <= bus.MRead ? READ : WRITE;
        if (bus.MRead && bus.MWrite) r_err <= 1'b1;
      end
      if (r_state == ISSUE) r_pending <= w_pendingNext;
      // Read data returns one cycle after issue, so the lane tag trails by one edge.
      r_rdVld  <= (r_state == ISSUE) && (r_op == READ);
      r_rdLane <= w_lane;
      if (r_rdVld) r_q[r_rdLane*DATA_W +: DATA_W] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_sp_mem_responder.sv
// Scoreboard bench for sp_mem_responder: a transaction-level memory model predicts
// strobe sequence, read data, err and handshake latency; a monitor checks them.
module tb_sp_mem_responder;
  import tinygpu_mem_pkg::*;

  localparam int N  = 8;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } issue_t;

  typedef struct {
    logic [N*DW-1:0] q;
    bit              err;
    int              lat;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sp_mem_responder_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) busIf ();

  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;
  logic          memWe;
  logic          memRe;

  sp_mem_responder #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (busIf),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_we    (memWe),
    .mem_re    (memRe),
    .mem_rdata (memRdata)
  );

  logic [DW-1:0] ram    [0:65535];
  logic [DW-1:0] refMem [0:65535];
  logic [DW-1:0] expQ   [N];
  bit            expErr;
  issue_t        issueQ[$];
  resp_t         respQ[$];
  int            total = 0;
  int            bad = 0;

  // Synchronous single-port RAM: read data appears the cycle after the sampling edge.
  always @(posedge clk) begin
    if (memWe) ram[memAddr] <= memWdata;
    if (memRe) memRdata <= ram[memAddr];
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModelOnReset();
    issueQ.delete();
    respQ.delete();
    expErr = 1'b0;
    for (int i = 0; i < N; i++) expQ[i] = '0;
  endtask

  // Transaction-level prediction: lanes serviced in ascending order, so later lanes win.
  task automatic pushExpect(input bit rd, input bit wr, input logic [N-1:0] enM,
                            input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    issue_t it;
    resp_t  r;
    int     n;
    logic [AW-1:0] ai;
    n = 0;
    for (int i = 0; i < N; i++) begin
      if (enM[i]) begin
        ai       = a[i*AW +: AW];
        it.we    = !rd;
        it.addr  = ai;
        it.wdata = d[i*DW +: DW];
        issueQ.push_back(it);
        n++;
        if (rd) expQ[i] = refMem[ai];
        else    refMem[ai] = d[i*DW +: DW];
      end
    end
    if (rd && wr) expErr = 1'b1;
    for (int i = 0; i < N; i++) r.q[i*DW +: DW] = expQ[i];
    r.err = expErr;
    r.lat = (n == 0) ? 0 : (rd ? n + 1 : n);
    respQ.push_back(r);
  endtask

  task automatic finishHandshake(input int hold);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (busIf.MReady) got = 1'b1;
    end
    checkOutput("mready_arrives", 128'(got), 128'(1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("mready_hold", 128'(busIf.MReady), 128'(1));
    end
    #1;
    busIf.MRead  = 1'b0;
    busIf.MWrite = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mready_release", 128'(busIf.MReady), 128'(0));
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [N-1:0] enM,
                               input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                               input int hold);
    pushExpect(rd, wr, enM, a, d);
    @(negedge clk);
    #1;
    busIf.MRead  = rd;
    busIf.MWrite = wr;
    busIf.en     = enM;
    busIf.addr   = a;
    busIf.data   = d;
    @(posedge clk);
    #1;
    busIf.en   = N'($urandom);
    busIf.addr = {$urandom, $urandom, $urandom, $urandom};
    busIf.data = {$urandom, $urandom, $urandom, $urandom};
    finishHandshake(hold);
  endtask

  // Monitor: every strobe and every MReady rise is checked against the scoreboard.
  int latCnt = 0;
  bit prevM = 1'b0;
  always @(negedge clk) begin
    issue_t it;
    resp_t  r;
    if (!reset) begin
      latCnt = 0;
      prevM  = 1'b0;
    end else begin
      if (memWe || memRe) begin
        if (issueQ.size() == 0) begin
          checkOutput("strobe_unexpected", 128'({memWe, memRe}), 128'(0));
        end else begin
          it = issueQ.pop_front();
          checkOutput("strobe_we", 128'(memWe), 128'(it.we));
          checkOutput("strobe_re", 128'(memRe), 128'(!it.we));
          checkOutput("strobe_addr", 128'(memAddr), 128'(it.addr));
          if (it.we) checkOutput("strobe_wdata", 128'(memWdata), 128'(it.wdata));
        end
      end
      if (busIf.MReady && !prevM) begin
        if (respQ.size() == 0) begin
          checkOutput("resp_unexpected", 128'(busIf.MReady), 128'(0));
        end else begin
          r = respQ.pop_front();
          checkOutput("resp_q", busIf.q, r.q);
          checkOutput("resp_err", 128'(busIf.err), 128'(r.err));
          checkOutput("resp_latency", 128'(latCnt), 128'(r.lat));
        end
      end
      if ((busIf.MRead || busIf.MWrite) && !busIf.MReady) latCnt++;
      else if (!(busIf.MRead || busIf.MWrite)) latCnt = 0;
      prevM = busIf.MReady;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mready"}, 128'(busIf.MReady), 128'(0));
    checkOutput({tag, "_err"}, 128'(busIf.err), 128'(0));
    checkOutput({tag, "_q"}, busIf.q, 128'(0));
    checkOutput({tag, "_strobes"}, 128'({memWe, memRe}), 128'(0));
    checkOutput({tag, "_maddr"}, 128'({memAddr, memWdata}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N*AW-1:0] aV;
    logic [N*DW-1:0] dV;
    int op;
    busIf.MRead  = 1'b0;
    busIf.MWrite = 1'b0;
    busIf.en     = '0;
    busIf.addr   = '0;
    busIf.data   = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = '0;
      refMem[i] = '0;
    end
    clearModelOnReset();
    #12;
    checkResetState("reset_initial");
    @(negedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < N; i++) begin
      aV[i*AW +: AW] = AW'(2 * i);
      dV[i*DW +: DW] = DW'(16'h0100 + i);
    end
    applyStimulus(1'b0, 1'b1, 8'hFF, aV, dV, 1);
    applyStimulus(1'b1, 1'b0, 8'hFF, aV, dV, 3);

    for (int i = 0; i < N; i++) aV[i*AW +: AW] = AW'(2 * (7 - i));
    applyStimulus(1'b1, 1'b0, 8'b1010_0100, aV, dV, 0);

    applyStimulus(1'b0, 1'b1, 8'h00, aV, dV, 1);

    for (int i = 0; i < N; i++) aV[i*AW +: AW] = 16'h0040;
    dV[1*DW +: DW] = 16'hAAAA;
    dV[6*DW +: DW] = 16'h5555;
    applyStimulus(1'b0, 1'b1, 8'b0100_0010, aV, dV, 0);
    applyStimulus(1'b1, 1'b0, 8'b0000_0001, aV, dV, 0);

    for (int i = 0; i < N; i++) aV[i*AW +: AW] = AW'(2 * i);
    applyStimulus(1'b1, 1'b1, 8'hFF, aV, dV, 1);
    applyStimulus(1'b0, 1'b1, 8'h0F, aV, dV, 0);

    @(negedge clk);
    #1 reset = 1'b0;
    clearModelOnReset();
    #1 checkResetState("reset_idle");
    @(negedge clk);
    #1 reset = 1'b1;

    pushExpect(1'b1, 1'b0, 8'hFF, aV, dV);
    @(negedge clk);
    #1;
    busIf.MRead = 1'b1;
    busIf.en    = 8'hFF;
    busIf.addr  = aV;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    clearModelOnReset();
    #1 checkResetState("reset_midread");
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_quiet_strobes", 128'({memWe, memRe}), 128'(0));
    end
    pushExpect(1'b1, 1'b0, 8'hFF, aV, dV);
    #1 reset = 1'b1;
    finishHandshake(1);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        aV[i*AW +: AW] = AW'($urandom_range(0, 15));
        dV[i*DW +: DW] = DW'($urandom);
      end
      op = $urandom_range(0, 3);
      applyStimulus(op == 0 || op == 2, op != 0, N'($urandom), aV, dV, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    checkOutput("issue_queue_drained", 128'(issueQ.size()), 128'(0));
    checkOutput("resp_queue_drained", 128'(respQ.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
